// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the scratchpad memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned NUM_BUS    = 3;
    localparam int unsigned MEM_ADDR_W = 6;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_IDX_W  = 2;

    typedef logic [BUS_IDX_W-1:0] bus_idx_t;

endpackage

// File: rtl/mem_grant_alloc.sv
// Rotated round-robin scan assigning up to NUM_BUS requests per cycle to buses,
// skipping requests that would create a same-cycle address hazard.
module mem_grant_alloc
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]           i_valid,
    input  logic [NUM_REQ-1:0]           i_we,
    input  logic [NUM_REQ*ADDR_W-1:0]    i_addr,
    input  logic [IDX_W-1:0]             i_rr_ptr,
    output logic [NUM_REQ-1:0]           o_grant,
    output logic [NUM_REQ*BUS_IDX_W-1:0] o_bus_idx,
    output logic [IDX_W-1:0]             o_last_idx,
    output logic                         o_any_grant
);

    always_comb begin : p_scan
        logic [NUM_REQ-1:0] gnt;
        int unsigned        n_grant;
        int unsigned        idx;
        logic               hazard;

        gnt         = '0;
        o_bus_idx   = '0;
        o_last_idx  = '0;
        o_any_grant = 1'b0;
        n_grant     = 0;
        idx         = 0;
        hazard      = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            idx    = (32'(i_rr_ptr) + j) % NUM_REQ;
            hazard = 1'b0;
            // Only load-load sharing of an address is safe within one cycle.
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (gnt[k] && (i_addr[k*ADDR_W+:ADDR_W] == i_addr[idx*ADDR_W+:ADDR_W])
                        && (i_we[k] || i_we[idx])) begin
                    hazard = 1'b1;
                end
            end
            if (i_valid[idx] && !hazard && (n_grant < NUM_BUS)) begin
                gnt[idx]                               = 1'b1;
                o_bus_idx[idx*BUS_IDX_W+:BUS_IDX_W]    = BUS_IDX_W'(n_grant);
                o_last_idx                             = IDX_W'(idx);
                o_any_grant                            = 1'b1;
                n_grant                                = n_grant + 1;
            end
        end
        o_grant = gnt;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the 3-bus scratchpad memory among NUM_REQ requesters with round-robin
// allocation, same-address hazard deferral and registered one-cycle responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = mem_arb_pkg::DATA_W,
    parameter int unsigned ADDR_W  = MEM_ADDR_W
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*32-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_rdata,
    output logic [31:0]           bus0_ld_addr,
    output logic [31:0]           bus1_ld_addr,
    output logic [31:0]           bus2_ld_addr,
    output logic [31:0]           bus0_st_addr,
    output logic [31:0]           bus1_st_addr,
    output logic [31:0]           bus2_st_addr,
    output logic [31:0]           bus0_data_in,
    output logic [31:0]           bus1_data_in,
    output logic [31:0]           bus2_data_in,
    output logic                  write0,
    output logic                  write1,
    output logic                  write2,
    input  logic [31:0]           bus0_from_mem,
    input  logic [31:0]           bus1_from_mem,
    input  logic [31:0]           bus2_from_mem
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]             r_rr_ptr;
    logic [NUM_REQ-1:0]           r_rsp_valid;
    logic [NUM_REQ*DATA_W-1:0]    r_rsp_rdata;

    logic [NUM_REQ-1:0]           w_valid;
    logic [NUM_REQ*ADDR_W-1:0]    w_addr_lo;
    logic [NUM_REQ-1:0]           w_grant;
    logic [NUM_REQ*BUS_IDX_W-1:0] w_bus_idx;
    logic [IDX_W-1:0]             w_last_idx;
    logic                         w_any_grant;
    logic [IDX_W-1:0]             w_rr_next;

    logic [BUS_ADDR_W-1:0]        w_ld_addr  [NUM_BUS];
    logic [BUS_ADDR_W-1:0]        w_st_addr  [NUM_BUS];
    logic [31:0]                  w_data_in  [NUM_BUS];
    logic [31:0]                  w_from_mem [NUM_BUS];
    logic [NUM_BUS-1:0]           w_write;

    // Gating valid with reset keeps every bus idle and write-disabled in reset.
    assign w_valid = req_valid & {NUM_REQ{RST_N}};

    always_comb begin
        w_addr_lo = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_addr_lo[i*ADDR_W+:ADDR_W] = req_addr[i*32+:ADDR_W];
        end
    end

    mem_grant_alloc #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .IDX_W   (IDX_W)
    ) u_alloc (
        .i_valid     (w_valid),
        .i_we        (req_we),
        .i_addr      (w_addr_lo),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_bus_idx   (w_bus_idx),
        .o_last_idx  (w_last_idx),
        .o_any_grant (w_any_grant)
    );

    assign w_rr_next = (w_last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_last_idx + 1'b1;

    always_comb begin
        bus_idx_t b;
        b = '0;
        for (int unsigned k = 0; k < NUM_BUS; k++) begin
            w_ld_addr[k] = '0;
            w_st_addr[k] = '0;
            w_data_in[k] = '0;
        end
        w_write = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                b = w_bus_idx[i*BUS_IDX_W+:BUS_IDX_W];
                if (req_we[i]) begin
                    w_st_addr[b] = req_addr[i*32+:32];
                    w_data_in[b] = 32'(req_wdata[i*DATA_W+:DATA_W]);
                    w_write[b]   = 1'b1;
                end else begin
                    w_ld_addr[b] = BUS_ADDR_W'(req_addr[i*32+:ADDR_W]);
                end
            end
        end
    end

    assign w_from_mem[0] = bus0_from_mem;
    assign w_from_mem[1] = bus1_from_mem;
    assign w_from_mem[2] = bus2_from_mem;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_grant;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i]) begin
                    r_rsp_rdata[i*DATA_W+:DATA_W] <= req_we[i] ? '0 :
                        DATA_W'(w_from_mem[w_bus_idx[i*BUS_IDX_W+:BUS_IDX_W]]);
                end
            end
            if (w_any_grant) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign req_ready    = w_grant;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign bus0_ld_addr = w_ld_addr[0];
    assign bus1_ld_addr = w_ld_addr[1];
    assign bus2_ld_addr = w_ld_addr[2];
    assign bus0_st_addr = w_st_addr[0];
    assign bus1_st_addr = w_st_addr[1];
    assign bus2_st_addr = w_st_addr[2];
    assign bus0_data_in = w_data_in[0];
    assign bus1_data_in = w_data_in[1];
    assign bus2_data_in = w_data_in[2];
    assign write0       = w_write[0];
    assign write1       = w_write[1];
    assign write2       = w_write[2];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 64 x 32 negedge-write memory model.
module tb_mem_port_arbiter;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_we = '0;
    logic [127:0] req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [127:0] rsp_rdata;
    logic [31:0]  bus0_ld_addr, bus1_ld_addr, bus2_ld_addr;
    logic [31:0]  bus0_st_addr, bus1_st_addr, bus2_st_addr;
    logic [31:0]  bus0_data_in, bus1_data_in, bus2_data_in;
    logic         write0, write1, write2;
    logic [31:0]  bus0_from_mem, bus1_from_mem, bus2_from_mem;

    logic [31:0]  mem [64];
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (write0) mem[bus0_st_addr[5:0]] <= bus0_data_in;
        if (write1) mem[bus1_st_addr[5:0]] <= bus1_data_in;
        if (write2) mem[bus2_st_addr[5:0]] <= bus2_data_in;
    end

    assign bus0_from_mem = mem[bus0_ld_addr[5:0]];
    assign bus1_from_mem = mem[bus1_ld_addr[5:0]];
    assign bus2_from_mem = mem[bus2_ld_addr[5:0]];

    mem_port_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (32),
        .ADDR_W  (6)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .bus0_ld_addr  (bus0_ld_addr),
        .bus1_ld_addr  (bus1_ld_addr),
        .bus2_ld_addr  (bus2_ld_addr),
        .bus0_st_addr  (bus0_st_addr),
        .bus1_st_addr  (bus1_st_addr),
        .bus2_st_addr  (bus2_st_addr),
        .bus0_data_in  (bus0_data_in),
        .bus1_data_in  (bus1_data_in),
        .bus2_data_in  (bus2_data_in),
        .write0        (write0),
        .write1        (write1),
        .write2        (write2),
        .bus0_from_mem (bus0_from_mem),
        .bus1_from_mem (bus1_from_mem),
        .bus2_from_mem (bus2_from_mem)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid[i]       = v;
        req_we[i]          = we;
        req_addr[i*32+:32] = a;
        req_wdata[i*32+:32] = d;
    endtask

    task automatic test_reset();
        #2 RST_N = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 32'(i + 1), 32'hA1 + 32'(i));
        tick();
        tick();
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++; $display("FAIL rst_ready: got %b want 0000", req_ready);
        end
        n_cmp++;
        if ({write2, write1, write0} !== 3'b000) begin
            n_err++; $display("FAIL rst_write: got %b want 000", {write2, write1, write0});
        end
        n_cmp++;
        if (rsp_valid !== 4'b0000 || rsp_rdata !== '0) begin
            n_err++; $display("FAIL rst_rsp: got %b/%h want 0/0", rsp_valid, rsp_rdata);
        end
        n_cmp++;
        if (bus0_st_addr !== 32'h0 || bus0_data_in !== 32'h0) begin
            n_err++; $display("FAIL rst_bus: got %h/%h want 0/0", bus0_st_addr, bus0_data_in);
        end
        RST_N = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0111) begin
            n_err++; $display("FAIL rel_ready: got %b want 0111", req_ready);
        end
        n_cmp++;
        if ({write2, write1, write0} !== 3'b111) begin
            n_err++; $display("FAIL rel_write: got %b want 111", {write2, write1, write0});
        end
        n_cmp++;
        if (bus0_st_addr !== 32'd1 || bus1_st_addr !== 32'd2 || bus2_st_addr !== 32'd3) begin
            n_err++; $display("FAIL rel_st_addr: got %h %h %h want 1 2 3",
                              bus0_st_addr, bus1_st_addr, bus2_st_addr);
        end
        n_cmp++;
        if (bus2_data_in !== 32'hA3) begin
            n_err++; $display("FAIL rel_data2: got %h want a3", bus2_data_in);
        end
    endtask

    task automatic test_store_burst();
        tick();
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b1, 32'(i + 1), 32'hA1 + 32'(i));
        #1;
        n_cmp++;
        if (rsp_valid !== 4'b0111 || rsp_rdata[31:0] !== 32'h0) begin
            n_err++; $display("FAIL st_rsp: got %b/%h want 0111/0", rsp_valid, rsp_rdata[31:0]);
        end
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_err++; $display("FAIL st_ready2: got %b want 1000", req_ready);
        end
        n_cmp++;
        if (bus0_st_addr !== 32'd4 || bus0_data_in !== 32'hA4 || {write2, write1, write0} !== 3'b001)
        begin
            n_err++; $display("FAIL st_bus0: got %h/%h/%b want 4/a4/001",
                              bus0_st_addr, bus0_data_in, {write2, write1, write0});
        end
        tick();
        set_req(3, 1'b0, 1'b1, 32'd4, 32'hA4);
        #1;
        n_cmp++;
        if (rsp_valid !== 4'b1000) begin
            n_err++; $display("FAIL st_rsp2: got %b want 1000", rsp_valid);
        end
    endtask

    task automatic test_load_burst();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 32'(i + 1), 32'h0);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0111) begin
            n_err++; $display("FAIL ld_ready: got %b want 0111", req_ready);
        end
        n_cmp++;
        if (bus0_ld_addr !== 32'd1 || bus1_ld_addr !== 32'd2 || bus2_ld_addr !== 32'd3
                || bus0_st_addr !== 32'd0 || write0 !== 1'b0) begin
            n_err++; $display("FAIL ld_bus: got %h %h %h st %h w %b want 1 2 3 st 0 w 0",
                              bus0_ld_addr, bus1_ld_addr, bus2_ld_addr, bus0_st_addr, write0);
        end
        tick();
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 32'(i + 1), 32'h0);
        #1;
        n_cmp++;
        if (rsp_valid !== 4'b0111) begin
            n_err++; $display("FAIL ld_rsp_valid: got %b want 0111", rsp_valid);
        end
        n_cmp++;
        if (rsp_rdata[31:0] !== 32'hA1 || rsp_rdata[63:32] !== 32'hA2 || rsp_rdata[95:64] !== 32'hA3)
        begin
            n_err++; $display("FAIL ld_rdata: got %h %h %h want a1 a2 a3",
                              rsp_rdata[31:0], rsp_rdata[63:32], rsp_rdata[95:64]);
        end
        n_cmp++;
        if (req_ready !== 4'b1000 || bus0_ld_addr !== 32'd4) begin
            n_err++; $display("FAIL ld_req3: got %b/%h want 1000/4", req_ready, bus0_ld_addr);
        end
        tick();
        set_req(3, 1'b0, 1'b0, 32'd4, 32'h0);
        #1;
        n_cmp++;
        if (rsp_valid !== 4'b1000 || rsp_rdata[127:96] !== 32'hA4 || rsp_rdata[31:0] !== 32'hA1)
        begin
            n_err++; $display("FAIL ld_rsp3: got %b %h hold %h want 1000 a4 hold a1",
                              rsp_valid, rsp_rdata[127:96], rsp_rdata[31:0]);
        end
    endtask

    task automatic test_store_store();
        set_req(0, 1'b1, 1'b1, 32'd5, 32'h11);
        set_req(1, 1'b1, 1'b1, 32'd5, 32'h22);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL ss_ready: got %b want 0001", req_ready);
        end
        tick();
        set_req(0, 1'b0, 1'b1, 32'd5, 32'h11);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010 || bus0_st_addr !== 32'd5 || bus0_data_in !== 32'h22) begin
            n_err++; $display("FAIL ss_defer: got %b/%h/%h want 0010/5/22",
                              req_ready, bus0_st_addr, bus0_data_in);
        end
        tick();
        set_req(1, 1'b0, 1'b1, 32'd5, 32'h22);
        set_req(2, 1'b1, 1'b0, 32'd5, 32'h0);
        #1;
        n_cmp++;
        if (rsp_valid !== 4'b0010 || rsp_rdata[63:32] !== 32'h0) begin
            n_err++; $display("FAIL ss_rsp: got %b/%h want 0010/0", rsp_valid, rsp_rdata[63:32]);
        end
        n_cmp++;
        if (req_ready !== 4'b0100 || bus0_ld_addr !== 32'd5) begin
            n_err++; $display("FAIL ss_ld: got %b/%h want 0100/5", req_ready, bus0_ld_addr);
        end
        tick();
        set_req(2, 1'b0, 1'b0, 32'd5, 32'h0);
        #1;
        n_cmp++;
        if (rsp_rdata[95:64] !== 32'h22) begin
            n_err++; $display("FAIL ss_rdata: got %h want 22", rsp_rdata[95:64]);
        end
    endtask

    task automatic test_store_load();
        set_req(0, 1'b1, 1'b1, 32'd7, 32'h55);
        set_req(1, 1'b1, 1'b0, 32'd7, 32'h0);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL sl_ready: got %b want 0001", req_ready);
        end
        tick();
        set_req(0, 1'b0, 1'b1, 32'd7, 32'h55);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010 || bus0_ld_addr !== 32'd7) begin
            n_err++; $display("FAIL sl_defer: got %b/%h want 0010/7", req_ready, bus0_ld_addr);
        end
        tick();
        set_req(1, 1'b0, 1'b0, 32'd7, 32'h0);
        #1;
        n_cmp++;
        if (rsp_valid !== 4'b0010 || rsp_rdata[63:32] !== 32'h55) begin
            n_err++; $display("FAIL sl_rdata: got %b/%h want 0010/55", rsp_valid, rsp_rdata[63:32]);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_ready [4];
        int         gcount [4];
        exp_ready[0] = 4'b0111;
        exp_ready[1] = 4'b1011;
        exp_ready[2] = 4'b1101;
        exp_ready[3] = 4'b1110;
        for (int i = 0; i < 4; i++) gcount[i] = 0;
        // rr_ptr is 2 here; a lone grant to req3 brings it back to 0.
        set_req(3, 1'b1, 1'b0, 32'd1, 32'h0);
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_err++; $display("FAIL fair_align: got %b want 1000", req_ready);
        end
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 32'd1, 32'h0);
        #1;
        n_cmp++;
        if (bus0_ld_addr !== 32'd1 || bus1_ld_addr !== 32'd1 || bus2_ld_addr !== 32'd1) begin
            n_err++; $display("FAIL fair_ldld: got %h %h %h want 1 1 1",
                              bus0_ld_addr, bus1_ld_addr, bus2_ld_addr);
        end
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (req_ready !== exp_ready[c]) begin
                n_err++; $display("FAIL fair_cycle%0d: got %b want %b", c, req_ready, exp_ready[c]);
            end
            for (int i = 0; i < 4; i++) gcount[i] += int'(req_ready[i]);
            tick();
        end
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 32'd1, 32'h0);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (gcount[i] != 3) begin
                n_err++; $display("FAIL fair_count%0d: got %0d want 3", i, gcount[i]);
            end
        end
        n_cmp++;
        if (rsp_valid !== 4'b1110 || rsp_rdata[127:96] !== 32'hA1) begin
            n_err++; $display("FAIL fair_rsp: got %b/%h want 1110/a1", rsp_valid, rsp_rdata[127:96]);
        end
    endtask

    task automatic test_addr_alias();
        set_req(0, 1'b1, 1'b1, 32'h07, 32'h77);
        set_req(1, 1'b1, 1'b0, 32'h47, 32'h0);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001 || bus0_st_addr !== 32'h07 || write0 !== 1'b1) begin
            n_err++; $display("FAIL alias_ready: got %b/%h/%b want 0001/7/1",
                              req_ready, bus0_st_addr, write0);
        end
        tick();
        set_req(0, 1'b0, 1'b1, 32'h07, 32'h77);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010 || bus0_ld_addr !== 32'h07) begin
            n_err++; $display("FAIL alias_ldaddr: got %b/%h want 0010/07", req_ready, bus0_ld_addr);
        end
        tick();
        set_req(1, 1'b0, 1'b0, 32'h47, 32'h0);
        #1;
        n_cmp++;
        if (rsp_rdata[63:32] !== 32'h77) begin
            n_err++; $display("FAIL alias_rdata: got %h want 77", rsp_rdata[63:32]);
        end
    endtask

    task automatic test_reset_mid();
        set_req(2, 1'b1, 1'b0, 32'd1, 32'h0);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL mid_ready: got %b want 0100", req_ready);
        end
        tick();
        set_req(2, 1'b0, 1'b0, 32'd1, 32'h0);
        RST_N = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 4'b0000 || rsp_rdata !== '0) begin
            n_err++; $display("FAIL mid_drop: got %b/%h want 0/0", rsp_valid, rsp_rdata);
        end
        set_req(0, 1'b1, 1'b1, 32'd1, 32'hDEADBEEF);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000 || {write2, write1, write0} !== 3'b000) begin
            n_err++; $display("FAIL mid_nowrite: got %b/%b want 0000/000",
                              req_ready, {write2, write1, write0});
        end
        tick();
        tick();
        set_req(0, 1'b1, 1'b0, 32'd1, 32'h0);
        RST_N = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL mid_rel_ready: got %b want 0001", req_ready);
        end
        tick();
        set_req(0, 1'b0, 1'b0, 32'd1, 32'h0);
        #1;
        n_cmp++;
        if (rsp_valid !== 4'b0001 || rsp_rdata[31:0] !== 32'hA1) begin
            n_err++; $display("FAIL mid_mem_kept: got %b/%h want 0001/a1", rsp_valid, rsp_rdata[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_store_burst();
        test_load_burst();
        test_store_store();
        test_store_load();
        test_fairness();
        test_addr_alias();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
